// File: rtl/regfile_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_fifo_pkg
//  Brief    : Shared widths and depth for the register-file FIFO controller.
//  Revision : 1.0 - initial release
// ============================================================================
package regfile_fifo_pkg;
   localparam int DATA_W          = 4;
   localparam int ADDR_W          = 5;
   localparam int DEPTH           = 2 ** ADDR_W;
   localparam int CNT_W           = ADDR_W + 1;
   localparam int AFULL_LEVEL_DEF = 28;
endpackage
`default_nettype wire

// File: rtl/regfile_fifo_ptr.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_fifo_ptr
//  Brief    : Wrapping pointer with increment enable and next-value output.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_fifo_ptr
   import regfile_fifo_pkg::*;
#(
   parameter int WIDTH = ADDR_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_ptr,
   output logic [WIDTH-1:0] o_ptr_next
);

   logic [WIDTH-1:0] r_ptr;

   // Natural modulo-2**WIDTH wrap gives the 31 -> 0 rollover.
   assign o_ptr_next = r_ptr + WIDTH'(i_inc);
   assign o_ptr      = r_ptr;

   always_ff @(posedge clk) begin
      if (rst) r_ptr <= '0;
      else     r_ptr <= o_ptr_next;
   end

endmodule
`default_nettype wire

// File: rtl/regfile_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_fifo_ctrl
//  Brief    : Show-ahead FIFO controller around the 32x4 register-file BEL.
//             Define REGFILE_FIFO_REGISTERED_READ_EN for a registered port A.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_fifo_ctrl
   import regfile_fifo_pkg::*;
#(
   parameter int AFULL_LEVEL = AFULL_LEVEL_DEF
) (
   input  logic              UserCLK,
   input  logic              UserRST,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   output logic              full,
   output logic              almost_full,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              pop_valid,
   output logic [CNT_W-1:0]  count,
   output logic              ovf_err,
   output logic              udf_err,
   output logic [ADDR_W-1:0] W_ADR,
   output logic              W_en,
   output logic [DATA_W-1:0] D,
   output logic [ADDR_W-1:0] A_ADR,
   input  logic [DATA_W-1:0] AD
);

   logic [CNT_W-1:0]  r_count;
   logic              r_ovf;
   logic              r_udf;
   logic              w_full;
   logic              w_pop_valid;
   logic              w_push_acc;
   logic              w_pop_acc;
   logic [ADDR_W-1:0] w_wr_ptr;
   logic [ADDR_W-1:0] w_wr_ptr_next;
   logic [ADDR_W-1:0] w_rd_ptr;
   logic [ADDR_W-1:0] w_rd_ptr_next;
   logic              w_unused;

   assign w_full     = (r_count == CNT_W'(DEPTH));
   assign w_push_acc = push && !w_full;
   assign w_pop_acc  = pop && w_pop_valid;

   regfile_fifo_ptr #(.WIDTH(ADDR_W)) u_wr_ptr (
      .clk        (UserCLK),
      .rst        (UserRST),
      .i_inc      (w_push_acc),
      .o_ptr      (w_wr_ptr),
      .o_ptr_next (w_wr_ptr_next)
   );

   regfile_fifo_ptr #(.WIDTH(ADDR_W)) u_rd_ptr (
      .clk        (UserCLK),
      .rst        (UserRST),
      .i_inc      (w_pop_acc),
      .o_ptr      (w_rd_ptr),
      .o_ptr_next (w_rd_ptr_next)
   );

`ifdef REGFILE_FIFO_REGISTERED_READ_EN
   logic r_stale;

   // Port A register sampled the old word when the head slot was written
   // in the same cycle; hold the head invalid until it is re-captured.
   always_ff @(posedge UserCLK) begin
      if (UserRST) r_stale <= 1'b0;
      else         r_stale <= W_en && (W_ADR == w_rd_ptr_next);
   end

   assign w_pop_valid = (r_count != '0) && !r_stale;
   assign A_ADR       = w_rd_ptr_next;
   assign w_unused    = ^w_wr_ptr_next;
`else
   assign w_pop_valid = (r_count != '0);
   assign A_ADR       = w_rd_ptr;
   assign w_unused    = ^{w_wr_ptr_next, w_rd_ptr_next};
`endif

   always_ff @(posedge UserCLK) begin
      if (UserRST) begin
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else begin
         r_count <= r_count + CNT_W'(w_push_acc) - CNT_W'(w_pop_acc);
         if (push && w_full)       r_ovf <= 1'b1;
         if (pop  && !w_pop_valid) r_udf <= 1'b1;
      end
   end

   assign W_en        = w_push_acc && !UserRST;
   assign W_ADR       = w_wr_ptr;
   assign D           = push_data;
   assign pop_data    = AD;
   assign pop_valid   = w_pop_valid;
   assign count       = r_count;
   assign full        = w_full;
   assign almost_full = (r_count >= CNT_W'(AFULL_LEVEL));
   assign ovf_err     = r_ovf;
   assign udf_err     = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_regfile_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_fifo_ctrl
//  Brief    : Directed self-checking bench with a 32x4 register-file model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_fifo_ctrl;

   logic       UserCLK;
   logic       UserRST;
   logic       push;
   logic [3:0] push_data;
   logic       full;
   logic       almost_full;
   logic       pop;
   logic [3:0] pop_data;
   logic       pop_valid;
   logic [5:0] count;
   logic       ovf_err;
   logic       udf_err;
   logic [4:0] W_ADR;
   logic       W_en;
   logic [3:0] D;
   logic [4:0] A_ADR;
   logic [3:0] AD;

   int checks = 0;
   int errors = 0;

   regfile_fifo_ctrl dut (
      .UserCLK     (UserCLK),
      .UserRST     (UserRST),
      .push        (push),
      .push_data   (push_data),
      .full        (full),
      .almost_full (almost_full),
      .pop         (pop),
      .pop_data    (pop_data),
      .pop_valid   (pop_valid),
      .count       (count),
      .ovf_err     (ovf_err),
      .udf_err     (udf_err),
      .W_ADR       (W_ADR),
      .W_en        (W_en),
      .D           (D),
      .A_ADR       (A_ADR),
      .AD          (AD)
   );

   // Register-file model: synchronous write, port A combinational or registered.
   logic [3:0] mem [32];
   always @(posedge UserCLK) if (W_en) mem[W_ADR] <= D;
`ifdef REGFILE_FIFO_REGISTERED_READ_EN
   logic [3:0] r_ad;
   always @(posedge UserCLK) r_ad <= mem[A_ADR];
   assign AD = r_ad;
`else
   assign AD = mem[A_ADR];
`endif

   initial UserCLK = 1'b0;
   always #5 UserCLK = ~UserCLK;

   task automatic cycle();
      @(posedge UserCLK);
      #1;
   endtask

   task automatic apply_reset();
      push = 1'b0; pop = 1'b0; UserRST = 1'b1;
      cycle();
      UserRST = 1'b0;
   endtask

   task automatic push_n(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         push = 1'b1; push_data = 4'((base + i) % 16);
         cycle();
      end
      push = 1'b0;
      cycle();
   endtask

   task automatic test_reset();
      UserRST = 1'b1; push = 1'b1; push_data = 4'h3; pop = 1'b0;
      cycle();
      #1;
      checks++;
      if (W_en !== 1'b0) begin errors++; $display("FAIL reset_w_en: got %b want 0", W_en); end
      cycle();
      push = 1'b0; UserRST = 1'b0;
      #1;
      checks++;
      if ({count, full, almost_full, pop_valid, ovf_err, udf_err} !== {6'd0, 5'b0}) begin
         errors++;
         $display("FAIL reset_state: count=%0d full=%b af=%b pv=%b ovf=%b udf=%b want all 0",
                  count, full, almost_full, pop_valid, ovf_err, udf_err);
      end
   endtask

   task automatic test_fill_drain();
      apply_reset();
      for (int i = 0; i < 32; i++) begin
         push = 1'b1; push_data = 4'(i % 16);
         #1;
         checks++;
         if ({W_en, W_ADR, D} !== {1'b1, 5'(i), 4'(i % 16)}) begin
            errors++;
            $display("FAIL fill_wport[%0d]: en=%b adr=%0d d=%h want 1 %0d %h", i, W_en, W_ADR, D, i, i % 16);
         end
         cycle();
         checks++;
         if ({count, almost_full, full} !== {6'(i + 1), (i + 1 >= 28), (i + 1 == 32)}) begin
            errors++;
            $display("FAIL fill_flags[%0d]: count=%0d af=%b full=%b want %0d %b %b",
                     i, count, almost_full, full, i + 1, (i + 1 >= 28), (i + 1 == 32));
         end
      end
      push = 1'b1; push_data = 4'hE;
      #1;
      checks++;
      if (W_en !== 1'b0) begin errors++; $display("FAIL ovf_w_en: got %b want 0", W_en); end
      cycle();
      push = 1'b0;
      checks++;
      if ({ovf_err, count} !== {1'b1, 6'd32}) begin
         errors++; $display("FAIL ovf_flag: ovf=%b count=%0d want 1 32", ovf_err, count);
      end
      cycle();
      for (int i = 0; i < 32; i++) begin
         pop = 1'b1;
         #1;
         checks++;
         if ({pop_valid, pop_data} !== {1'b1, 4'(i % 16)}) begin
            errors++;
            $display("FAIL drain[%0d]: pv=%b data=%h want 1 %h", i, pop_valid, pop_data, i % 16);
         end
         cycle();
      end
      pop = 1'b0;
      #1;
      checks++;
      if ({pop_valid, count, udf_err} !== {1'b0, 6'd0, 1'b0}) begin
         errors++; $display("FAIL drain_empty: pv=%b count=%0d udf=%b want 0 0 0", pop_valid, count, udf_err);
      end
      pop = 1'b1;
      cycle();
      pop = 1'b0;
      checks++;
      if ({udf_err, count} !== {1'b1, 6'd0}) begin
         errors++; $display("FAIL udf_flag: udf=%b count=%0d want 1 0", udf_err, count);
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 20; i++) begin
            push = 1'b1; push_data = 4'((3 * i + r) % 16);
            #1;
            checks++;
            if (W_ADR !== 5'((20 * r + i) % 32)) begin
               errors++; $display("FAIL wrap_wadr[%0d,%0d]: got %0d want %0d", r, i, W_ADR, (20 * r + i) % 32);
            end
            cycle();
         end
         push = 1'b0;
         cycle();
         for (int i = 0; i < 20; i++) begin
            pop = 1'b1;
            #1;
            checks++;
            if ({pop_valid, pop_data} !== {1'b1, 4'((3 * i + r) % 16)}) begin
               errors++;
               $display("FAIL wrap_data[%0d,%0d]: pv=%b data=%h want 1 %h", r, i, pop_valid, pop_data, (3 * i + r) % 16);
            end
            cycle();
         end
         pop = 1'b0;
      end
      push = 1'b1; push_data = 4'h0;
      #1;
      checks++;
      if ({W_ADR, A_ADR, count} !== {5'd8, 5'd8, 6'd0}) begin
         errors++; $display("FAIL wrap_ptrs: wadr=%0d aadr=%0d count=%0d want 8 8 0", W_ADR, A_ADR, count);
      end
      push = 1'b0;
      cycle();
   endtask

   task automatic test_simultaneous();
      // Full: pop wins, pushed 0x7 must never appear.
      apply_reset();
      push_n(32, 0);
      push = 1'b1; pop = 1'b1; push_data = 4'h7;
      #1;
      checks++;
      if ({W_en, pop_data} !== {1'b0, 4'h0}) begin
         errors++; $display("FAIL simul_full_port: en=%b head=%h want 0 0", W_en, pop_data);
      end
      cycle();
      push = 1'b0;
      checks++;
      if ({count, ovf_err} !== {6'd31, 1'b1}) begin
         errors++; $display("FAIL simul_full_count: count=%0d ovf=%b want 31 1", count, ovf_err);
      end
      for (int i = 1; i < 32; i++) begin
         #1;
         checks++;
         if ({pop_valid, pop_data} !== {1'b1, 4'(i % 16)}) begin
            errors++; $display("FAIL simul_full_drain[%0d]: pv=%b data=%h want 1 %h", i, pop_valid, pop_data, i % 16);
         end
         cycle();
      end
      pop = 1'b0;
      #1;
      checks++;
      if ({pop_valid, count} !== {1'b0, 6'd0}) begin
         errors++; $display("FAIL simul_full_end: pv=%b count=%0d want 0 0", pop_valid, count);
      end
      // Empty: only the push is accepted, the pop counts as underflow.
      apply_reset();
      push = 1'b1; pop = 1'b1; push_data = 4'h3;
      cycle();
      push = 1'b0; pop = 1'b0;
      checks++;
      if ({count, udf_err} !== {6'd1, 1'b1}) begin
         errors++; $display("FAIL simul_empty: count=%0d udf=%b want 1 1", count, udf_err);
      end
      cycle();
      checks++;
      if ({pop_valid, pop_data} !== {1'b1, 4'h3}) begin
         errors++; $display("FAIL simul_empty_data: pv=%b data=%h want 1 3", pop_valid, pop_data);
      end
      // Mid-level: both accepted, count holds.
      apply_reset();
      push_n(5, 1);
      push = 1'b1; pop = 1'b1; push_data = 4'h9;
      #1;
      checks++;
      if ({W_en, pop_data} !== {1'b1, 4'h1}) begin
         errors++; $display("FAIL simul_mid_port: en=%b head=%h want 1 1", W_en, pop_data);
      end
      cycle();
      push = 1'b0;
      checks++;
      if (count !== 6'd5) begin errors++; $display("FAIL simul_mid_count: got %0d want 5", count); end
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (pop_data !== ((i == 4) ? 4'h9 : 4'(i + 2))) begin
            errors++; $display("FAIL simul_mid_drain[%0d]: got %h want %h", i, pop_data, (i == 4) ? 9 : i + 2);
         end
         cycle();
      end
      pop = 1'b0;
   endtask

   task automatic test_latency();
      apply_reset();
      push = 1'b1; push_data = 4'hA;
      cycle();
      push = 1'b0;
`ifdef REGFILE_FIFO_REGISTERED_READ_EN
      checks++;
      if (pop_valid !== 1'b0) begin errors++; $display("FAIL latency_early: pv=%b want 0", pop_valid); end
      cycle();
`endif
      checks++;
      if ({pop_valid, pop_data} !== {1'b1, 4'hA}) begin
         errors++; $display("FAIL latency_first: pv=%b data=%h want 1 a", pop_valid, pop_data);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      pop = 1'b1;
      cycle();
      pop = 1'b0;
      push_n(10, 0);
      checks++;
      if ({count, udf_err} !== {6'd10, 1'b1}) begin
         errors++; $display("FAIL mid_pre: count=%0d udf=%b want 10 1", count, udf_err);
      end
      UserRST = 1'b1;
      cycle();
      UserRST = 1'b0;
      checks++;
      if ({count, pop_valid, ovf_err, udf_err} !== {6'd0, 3'b000}) begin
         errors++;
         $display("FAIL mid_reset: count=%0d pv=%b ovf=%b udf=%b want 0 0 0 0", count, pop_valid, ovf_err, udf_err);
      end
      push_n(1, 5);
      pop = 1'b1;
      #1;
      checks++;
      if ({pop_valid, pop_data} !== {1'b1, 4'h5}) begin
         errors++; $display("FAIL mid_after: pv=%b data=%h want 1 5", pop_valid, pop_data);
      end
      cycle();
      pop = 1'b0;
      checks++;
      if (count !== 6'd0) begin errors++; $display("FAIL mid_after_count: got %0d want 0", count); end
   endtask

   initial begin
      UserRST = 1'b1; push = 1'b0; pop = 1'b0; push_data = 4'h0;
      test_reset();
      test_fill_drain();
      test_wrap();
      test_simultaneous();
      test_latency();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/regfile_fifo_ctrl.md
# regfile_fifo_ctrl

FIFO controller that drives the write port and read port A of the 32x4 register-file BEL, turning it into a 32-entry, 4-bit show-ahead FIFO for fabric user logic. It generates the write address/enable and read address and consumes the read data. It sits beside the register file in the same tile, with the fabric switch matrix on its user side.

## Interface
- DATA_W, 4, entry width; matches the register file.
- ADDR_W, 5, pointer width; depth = 2**ADDR_W = 32.
- AFULL_LEVEL, 28, almost_full asserts when count >= this value.

- UserCLK  in  1  user clock; the single clock domain; the register file runs on the same clock.
- UserRST  in  1  reset; synchronous, active-high.
- push  in  1  write request.
- push_data  in  DATA_W  write data.
- full  out  1  count == 32.
- almost_full  out  1  count >= AFULL_LEVEL.
- pop  in  1  consumer accepts the head entry.
- pop_data  out  DATA_W  head entry; valid only while pop_valid = 1.
- pop_valid  out  1  head entry available.
- count  out  ADDR_W+1  current occupancy, 0..32.
- ovf_err  out  1  sticky; set by push while full.
- udf_err  out  1  sticky; set by pop while pop_valid = 0.
- W_ADR  out  ADDR_W  to register file write address.
- W_en  out  1  to register file write enable.
- D  out  DATA_W  to register file write data.
- A_ADR  out  ADDR_W  to register file port-A read address.
- AD  in  DATA_W  from register file port-A read data.

## Operation
- State: wr_ptr and rd_ptr (5-bit, wrap 31->0), count (6-bit), and the sticky error flags.
- Push is accepted when push && !full:
  - W_en = 1, W_ADR = wr_ptr, D = push_data, all combinational.
  - wr_ptr increments at the next edge.
- A push while full is dropped: W_en = 0 and ovf_err is set.
- Pop is accepted when pop && pop_valid: rd_ptr increments.
- A pop without pop_valid is ignored, and udf_err is set.
- count_next = count + push_acc - pop_acc.
- Simultaneous push and pop:
  - When full, the pop is accepted and the push is rejected, because full is evaluated on the current count. count goes to 31.
  - When empty, only the push is accepted.
  - Otherwise both are accepted and count is unchanged.
- pop_data = AD, passed straight through.
- Reset (UserRST = 1 at an edge):
  - Pointers and count go to 0; ovf_err and udf_err clear.
  - Outputs become full = 0, almost_full = 0, pop_valid = 0, W_en = 0, count = 0.
  - Reset applied mid-stream discards all contents. Register-file memory is not cleared.
- W_en is forced to 0 while UserRST = 1.

## Timing
- Without the macro (register file in combinational-read mode):
  - A_ADR = rd_ptr.
  - pop_valid = (count != 0).
  - First-word latency is 1 cycle: push accepted at edge E0, so pop_valid is high after E0 with the correct pop_data.
- With the macro (register file in registered-read mode), see Configuration.
- The full and count outputs update at the edge after the accepted operation.

## Configuration
- Macro: REGFILE_FIFO_REGISTERED_READ_EN.
- Defined: the read data path matches the register file's registered port A.
  - A_ADR = rd_ptr_next = rd_ptr + pop_acc, so the register file's output register holds the new head after the edge.
  - stale flag: set at an edge where W_en = 1 and W_ADR == rd_ptr_next, because the output register captured the pre-write value. Cleared at the following edge.
  - pop_valid = (count != 0) && !stale.
  - First-word latency into an empty FIFO is 2 cycles.
  - Steady-state throughput is still 1 pop per cycle.
- Undefined: the combinational behaviour described under Timing. The stale logic is absent.

## Structure
- Package regfile_fifo_pkg holds DATA_W, ADDR_W, DEPTH = 32, and the count-width constant.
- One sub-module, regfile_fifo_ptr: a 5-bit wrapping pointer with increment enable, synchronous reset, and a combinational next-value output.
  - Instantiated twice: write pointer and read pointer.
- The controller contains no storage for data; the register file holds all entries.

## Test plan
- Reset then fill: 32 pushes of 0x0..0xF repeating.
  - After the 32nd edge: full = 1, count = 32, almost_full went high at count 28.
  - A 33rd push sets ovf_err = 1 and leaves W_en = 0.
- Drain after fill: 32 pops return 0,1,..,F,0,..,F in order.
  - Then pop_valid = 0 and count = 0.
  - One extra pop sets udf_err.
- Wrap-around: push 20, pop 20, push 20, pop 20.
  - Data stays in order and pointers end at 8.
  - W_ADR sequence crosses 31->0.
- Simultaneous events:
  - At count = 32, push + pop gives count 31 and the pushed data is dropped.
  - At count = 0, push + pop gives count 1 and udf_err = 0... except it is set, since pop arrived without pop_valid; the bench checks udf_err = 1.
  - At count = 5, push + pop keeps count = 5.
- Latency: push 0xA into an empty FIFO.
  - pop_valid = 1 with pop_data = 0xA one cycle later without the macro, two cycles later with it.
- Reset mid-stream: with count = 10, assert UserRST for one edge.
  - count = 0, pop_valid = 0, error flags cleared.
  - A following push/pop of 0x5 returns 0x5.
